// File: rtl/alu_pkg.sv
// alu_pkg: operation codes, FSM state encoding and opcode class masks
// shared by the execute-stage ALU and its combinational core.
// Ports: none (package).
package alu_pkg;

   typedef enum logic [3:0] {
      OP_AND  = 4'b0000,
      OP_OR   = 4'b0001,
      OP_ADD  = 4'b0010,
      OP_SLTI = 4'b0011,
      OP_SRA  = 4'b0100,
      OP_XOR  = 4'b0101,
      OP_SUB  = 4'b0110,
      OP_SLT  = 4'b0111,
      OP_BEQ  = 4'b1000,
      OP_SLL  = 4'b1001,
      OP_BLT  = 4'b1010,
      OP_BGE  = 4'b1011,
      OP_ADDI = 4'b1100,
      OP_SRL  = 4'b1101,
      OP_BNE  = 4'b1110,
      OP_ZERO = 4'b1111
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } exec_state_e;

   // One bit per opcode, indexed by the 4-bit code.
   // Shifts: 1001, 1101, 0100.
   localparam logic [15:0] OP_IS_SHIFT  = 16'h2210;
   // Branches: 1000, 1110, 1010, 1011.
   localparam logic [15:0] OP_IS_BRANCH = 16'h4D00;

endpackage

// File: rtl/alu_exec_unit_comb.sv
// alu_comb: purely combinational single-cycle ALU ops and compares.
// Ports: op (4-bit code), a/b operands in; result and compare condition out.
// Shift codes pass a through unchanged (the shift-by-zero result).
module alu_comb
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             cond
);

   logic lt;
   logic is_cmp;

   assign lt = $signed(a) < $signed(b);

   always_comb begin
      result = '0;
      cond   = 1'b0;
      is_cmp = 1'b0;
      case (op)
         OP_AND:            result = a & b;
         OP_OR:             result = a | b;
         OP_XOR:            result = a ^ b;
         OP_ADD, OP_ADDI:   result = a + b;
         OP_SUB:            result = a - b;
         OP_SLT, OP_SLTI: begin is_cmp = 1'b1; cond = lt;        end
         OP_BEQ:          begin is_cmp = 1'b1; cond = (a == b);  end
         OP_BNE:          begin is_cmp = 1'b1; cond = (a != b);  end
         OP_BLT:          begin is_cmp = 1'b1; cond = lt;        end
         OP_BGE:          begin is_cmp = 1'b1; cond = !lt;       end
         OP_SLL, OP_SRL, OP_SRA: result = a;
         default:           result = '0;
      endcase
      if (is_cmp) begin
         result = {{(WIDTH-1){1'b0}}, cond};
      end
   end

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with registered result, valid/ready on
// both sides; single-cycle ops finish in one cycle, shifts iterate 1 bit/cycle.
// Ports: clk, reset (sync, active-high), flush; in_valid/in_ready with
// Operation, SrcA, SrcB; out_valid/out_ready with ALUResult, BranchTaken.
module alu_exec_unit
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       Operation,
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] ALUResult,
   output logic             BranchTaken
);

   exec_state_e      state, state_nxt;
   logic [WIDTH-1:0] acc, acc_shifted, comb_result, result_q;
   logic [SHW-1:0]   cnt;
   logic [3:0]       op_q;
   logic             comb_cond, branch_q;
   logic             accept, start_shift;

   alu_comb #(.WIDTH(WIDTH)) u_comb (
      .op     (Operation),
      .a      (SrcA),
      .b      (SrcB),
      .result (comb_result),
      .cond   (comb_cond)
   );

   assign in_ready    = ((state == IDLE) || ((state == DONE) && out_ready))
                        && !reset && !flush;
   assign accept      = in_valid && in_ready;
   // Shift by zero takes the single-cycle path (alu_comb passes SrcA through).
   assign start_shift = OP_IS_SHIFT[Operation] && (SrcB[SHW-1:0] != '0);

   assign out_valid   = (state == DONE);
   assign ALUResult   = result_q;
   assign BranchTaken = branch_q;

   always_comb begin
      acc_shifted = acc;
      case (op_q)
         OP_SLL:  acc_shifted = {acc[WIDTH-2:0], 1'b0};
         OP_SRL:  acc_shifted = {1'b0, acc[WIDTH-1:1]};
         OP_SRA:  acc_shifted = {acc[WIDTH-1], acc[WIDTH-1:1]};
         default: acc_shifted = acc;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) state_nxt = start_shift ? SHIFT : DONE;
         end
         SHIFT: begin
            if (cnt == SHW'(1)) state_nxt = DONE;
         end
         DONE: begin
            if (out_ready) begin
               if (accept) state_nxt = start_shift ? SHIFT : DONE;
               else        state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      // accept already excludes flush, so this only needs to abort.
      if (flush) state_nxt = IDLE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc      <= '0;
         cnt      <= '0;
         op_q     <= '0;
         result_q <= '0;
         branch_q <= 1'b0;
      end else if (accept) begin
         if (start_shift) begin
            acc  <= SrcA;
            cnt  <= SrcB[SHW-1:0];
            op_q <= Operation;
         end else begin
            result_q <= comb_result;
            branch_q <= comb_cond && OP_IS_BRANCH[Operation];
         end
      end else if ((state == SHIFT) && !flush) begin
         acc <= acc_shifted;
         cnt <= cnt - 1'b1;
         // Last step writes straight to the result so DONE needs no extra cycle.
         if (cnt == SHW'(1)) begin
            result_q <= acc_shifted;
            branch_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

   logic        clk;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  Operation;
   logic [31:0] SrcA;
   logic [31:0] SrcB;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] ALUResult;
   logic        BranchTaken;

   alu_exec_unit #(.WIDTH(32), .SHW(5)) dut (
      .clk         (clk),
      .reset       (reset),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .Operation   (Operation),
      .SrcA        (SrcA),
      .SrcB        (SrcB),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .ALUResult   (ALUResult),
      .BranchTaken (BranchTaken)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        br;
      int          lat;
   } vec_t;

   typedef struct packed {
      logic [31:0] res;
      logic        br;
   } exp_t;

   exp_t sb[$];
   vec_t tbl[19];
   int   checks  = 0;
   int   fails   = 0;
   int   retired = 0;
   int   cyc     = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Scoreboard side: runs at every sampled falling edge.
   task automatic mon();
      exp_t e;
      if (reset || flush) begin
         sb.delete();
      end else if (out_valid && out_ready) begin
         retired++;
         checks++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL unexpected_result: got %h/%b, expected no result", ALUResult, BranchTaken);
         end else begin
            e = sb.pop_front();
            if (ALUResult !== e.res || BranchTaken !== e.br) begin
               fails++;
               $display("FAIL result: got %h/%b, expected %h/%b", ALUResult, BranchTaken, e.res, e.br);
            end
         end
      end
   endtask

   task automatic neg();
      @(negedge clk);
      mon();
   endtask

   task automatic pos();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic step();
      neg();
      pos();
   endtask

   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic eb);
      exp_t e;
      Operation = op;
      SrcA      = a;
      SrcB      = b;
      in_valid  = 1'b1;
      for (int k = 0; k < 100; k++) begin
         neg();
         if (in_ready) begin
            e.res = er;
            e.br  = eb;
            sb.push_back(e);
            pos();
            in_valid  = 1'b0;
            // Operands must be ignored after accept.
            Operation = 4'($urandom());
            SrcA      = $urandom();
            SrcB      = $urandom();
            return;
         end
         pos();
      end
      checks++;
      fails++;
      $display("FAIL accept_timeout: got no accept in 100 cycles, expected accept");
      in_valid = 1'b0;
   endtask

   // Called just after the accept edge; returns at the falling edge with out_valid.
   task automatic wait_result(input int exp_lat, input string name);
      int lat  = 1;
      int busy = 0;
      while (lat <= 100) begin
         neg();
         if (out_valid) break;
         if (!in_ready) busy++;
         pos();
         lat++;
      end
      chk({name, "_latency"}, lat, exp_lat);
      chk({name, "_in_ready_low_cycles"}, busy, exp_lat - 1);
   endtask

   initial begin
      int r0, c0, seen;

      tbl[0]  = '{4'b0010, 32'd5,         32'd7,          32'd12,         1'b0, 1};
      tbl[1]  = '{4'b0110, 32'd3,         32'd5,          32'hFFFFFFFE,   1'b0, 1};
      tbl[2]  = '{4'b1010, 32'hFFFFFFFF,  32'd1,          32'd1,          1'b1, 1};
      tbl[3]  = '{4'b1011, 32'hFFFFFFFF,  32'd1,          32'd0,          1'b0, 1};
      tbl[4]  = '{4'b1110, 32'h1234,      32'h1234,       32'd0,          1'b0, 1};
      tbl[5]  = '{4'b0100, 32'h80000000,  32'd4,          32'hF8000000,   1'b0, 5};
      tbl[6]  = '{4'b1101, 32'h80000000,  32'd4,          32'h08000000,   1'b0, 5};
      tbl[7]  = '{4'b1001, 32'hDEADBEEF,  32'h20,         32'hDEADBEEF,   1'b0, 1};
      tbl[8]  = '{4'b1001, 32'd1,         32'h2F,         32'h00008000,   1'b0, 16};
      tbl[9]  = '{4'b0000, 32'hF0F0,      32'hFF00,       32'hF000,       1'b0, 1};
      tbl[10] = '{4'b0001, 32'hF0F0,      32'h0F0F,       32'hFFFF,       1'b0, 1};
      tbl[11] = '{4'b0101, 32'hFF,        32'h0F,         32'hF0,         1'b0, 1};
      tbl[12] = '{4'b0011, 32'hFFFFFFFE,  32'd1,          32'd1,          1'b0, 1};
      tbl[13] = '{4'b0111, 32'd5,         32'hFFFFFFFF,   32'd0,          1'b0, 1};
      tbl[14] = '{4'b1000, 32'd7,         32'd7,          32'd1,          1'b1, 1};
      tbl[15] = '{4'b1100, 32'hFFFFFFFF,  32'd1,          32'd0,          1'b0, 1};
      tbl[16] = '{4'b1111, 32'h1234,      32'h5678,       32'd0,          1'b0, 1};
      tbl[17] = '{4'b0100, 32'h7FFFFFFF,  32'h1F,         32'd0,          1'b0, 32};
      tbl[18] = '{4'b1101, 32'hFFFFFFFF,  32'h21,         32'h7FFFFFFF,   1'b0, 2};

      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      Operation = '0; SrcA = '0; SrcB = '0;

      // Reset
      pos();
      neg();
      chk("reset_in_ready_low", in_ready, 1'b0);
      chk("reset_out_valid", out_valid, 1'b0);
      pos();
      reset = 1'b0;
      neg();
      chk("post_reset_in_ready", in_ready, 1'b1);
      chk("post_reset_result", ALUResult, 32'd0);
      chk("post_reset_branch", BranchTaken, 1'b0);
      pos();

      // Table of single ops with latency
      out_ready = 1'b1;
      for (int i = 0; i < 19; i++) begin
         issue(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].br);
         wait_result(tbl[i].lat, $sformatf("vec%0d", i));
         pos();
      end

      // Back-to-back: one result per cycle
      r0 = retired;
      c0 = cyc;
      issue(4'b0010, 32'd1,     32'd2,    32'd3,     1'b0);
      issue(4'b0101, 32'hF0,    32'hFF,   32'h0F,    1'b0);
      issue(4'b0001, 32'h100,   32'h1,    32'h101,   1'b0);
      chk("b2b_accept_cycles", cyc - c0, 3);
      neg();
      chk("b2b_retired", retired - r0, 3);
      pos();

      // Backpressure: hold 3 cycles, then retire and accept together
      out_ready = 1'b0;
      issue(4'b0010, 32'd10, 32'd20, 32'd30, 1'b0);
      for (int i = 0; i < 3; i++) begin
         neg();
         chk("hold_out_valid", out_valid, 1'b1);
         chk("hold_result", ALUResult, 32'd30);
         pos();
      end
      out_ready = 1'b1;
      Operation = 4'b0110; SrcA = 32'd9; SrcB = 32'd4; in_valid = 1'b1;
      neg();
      chk("retire_accept_same_cycle", {30'd0, out_valid, in_ready}, 32'd3);
      if (in_ready) sb.push_back('{32'd5, 1'b0});
      pos();
      in_valid = 1'b0;
      wait_result(1, "after_release");
      pos();

      // Flush mid-shift
      issue(4'b1001, 32'd1, 32'd10, 32'h400, 1'b0);
      step();
      flush = 1'b1;
      in_valid = 1'b1;
      neg();
      chk("flush_blocks_accept", in_ready, 1'b0);
      pos();
      flush = 1'b0;
      in_valid = 1'b0;
      neg();
      chk("flush_out_valid", out_valid, 1'b0);
      chk("flush_idle_in_ready", in_ready, 1'b1);
      pos();
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         neg();
         if (out_valid) seen++;
         pos();
      end
      chk("flush_no_result", seen, 0);
      issue(4'b0010, 32'd100, 32'd23, 32'd123, 1'b0);
      wait_result(1, "after_flush");
      pos();

      // Reset mid-shift after a taken branch
      issue(4'b1000, 32'd5, 32'd5, 32'd1, 1'b1);
      wait_result(1, "beq_taken");
      pos();
      issue(4'b0100, 32'h80000000, 32'd8, 32'hFF800000, 1'b0);
      step();
      reset = 1'b1;
      neg();
      chk("midshift_reset_in_ready", in_ready, 1'b0);
      pos();
      reset = 1'b0;
      neg();
      chk("midshift_reset_out_valid", out_valid, 1'b0);
      chk("midshift_reset_result", ALUResult, 32'd0);
      chk("midshift_reset_branch", BranchTaken, 1'b0);
      chk("midshift_reset_in_ready_after", in_ready, 1'b1);
      pos();
      issue(4'b0110, 32'd50, 32'd8, 32'd42, 1'b0);
      wait_result(1, "after_reset");
      pos();

      chk("scoreboard_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

- Execute-stage unit directly downstream of the ALU controller.
- Consumes the 4-bit `Operation` code plus two 32-bit operands and produces a registered result with valid/ready handshakes on both sides.
- Single-cycle ops complete in one cycle. Shifts run iteratively, one bit per cycle, replacing the barrel shifter to save area.
- Result feeds the EX/MEM boundary and branch-resolution logic.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width.
- `SHW`, 5, shift-amount width; equals log2(WIDTH).

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high; one clock, synchronous active-high reset.
- `flush`  in  1  synchronous abort of any in-flight op.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  unit can accept.
- `Operation`  in  4  ALU operation code.
- `SrcA`  in  WIDTH  operand A.
- `SrcB`  in  WIDTH  operand B; shift amount is `SrcB[SHW-1:0]`.
- `out_valid`  out  1  result held.
- `out_ready`  in  1  consumer takes result.
- `ALUResult`  out  WIDTH  registered result.
- `BranchTaken`  out  1  registered branch-condition flag.

## Operation
- Operation codes:
  - 0000 AND, 0001 OR, 0101 XOR.
  - 0010 ADD, 1100 ADD (ADDI form), 0110 SUB.
  - 0111 SLT, 0011 SLT (SLTI form); both signed.
  - 1001 SLL, 1101 SRL, 0100 SRA.
  - 1000 BEQ, 1110 BNE, 1010 BLT (signed), 1011 BGE (signed).
  - 1111: result 0.
- Arithmetic: ADD/SUB wrap mod 2^WIDTH; no overflow flag.
- Compares (SLT, BEQ, BNE, BLT, BGE): `ALUResult` = {WIDTH-1 zeros, cond}.
- `BranchTaken` = cond for codes 1000/1110/1010/1011; 0 for all others.
- FSM states:
  - IDLE: `in_ready`=1. On accept (`in_valid`&&`in_ready`):
    - Non-shift, or shift with shamt=0: latch result → DONE.
    - Shift with shamt≠0: load acc=SrcA, cnt=shamt, latch op → SHIFT.
  - SHIFT: `in_ready`=0. Each cycle: acc shifts one bit (SRA replicates acc[WIDTH-1]); cnt decrements. When cnt==1, the final shifted value is written to `ALUResult` → DONE.
  - DONE: `out_valid`=1; `ALUResult`/`BranchTaken` stable until handshake.
    - `out_ready`=1 and `in_valid`=1: result retires and the new request is accepted in the same cycle, as in IDLE.
    - `out_ready`=1 and no new request: → IDLE.
    - `out_ready`=0: hold.
- `in_ready` = (IDLE || (DONE && `out_ready`)) && !`reset` && !`flush`.
- Operands are sampled only at accept; later changes on `SrcA`/`SrcB`/`Operation` are ignored.

## Timing
- Reset (any state, including mid-shift): state IDLE, `out_valid`=0, `ALUResult`=0, `BranchTaken`=0, acc=0, cnt=0. `in_ready` is 0 while `reset`=1 and 1 the cycle after.
- Latency, accept edge → `out_valid` high:
  - Non-shift, and shifts with shamt=0: 1 cycle.
  - Shift: shamt+1 cycles.
- Throughput: 1 op/cycle for non-shift ops while `out_ready`=1.
- `flush` has priority over accept and retire:
  - Next state is IDLE, `out_valid`=0, no request accepted that cycle.
  - `ALUResult` keeps its value; it is don't-care while `out_valid`=0.
- `reset` has priority over `flush`.
- `out_valid` never drops without a handshake, a flush, or a reset.

## Structure
- Shared package `alu_pkg`:
  - `alu_op_e` enum with the 4-bit codes above.
  - `exec_state_e` enum {IDLE, SHIFT, DONE}.
  - Helper constant `OP_IS_SHIFT` (codes 1001/1101/0100).
  - Helper constant `OP_IS_BRANCH` (codes 1000/1110/1010/1011).
- One sub-module, `alu_comb`: purely combinational single-cycle ops and compares (Operation, A, B → result, cond).
- `alu_exec_unit` owns the FSM, shift accumulator and counter, and the output registers.

## Test plan
- ADD 0010, A=5, B=7, `out_ready`=1 → `out_valid` 1 cycle after accept, `ALUResult`=12, `BranchTaken`=0. Repeat with SUB 0110, A=3, B=5 → 0xFFFFFFFE.
- BLT 1010, A=0xFFFFFFFF, B=1 → `ALUResult`=1, `BranchTaken`=1. BGE 1011, same operands → 0/0. BNE 1110, A=B=0x1234 → 0/0.
- SRA 0100, A=0x80000000, B=4 → `in_ready`=0 for 4 cycles, `out_valid` 5 cycles after accept, `ALUResult`=0xF8000000. SRL, same operands → 0x08000000.
- SLL 1001, A=0xDEADBEEF, B=0x20 (shamt 0) → 1-cycle latency, result 0xDEADBEEF. SLL, A=1, B=0x2F (shamt 15) → 0x00008000 after 16 cycles.
- Back-to-back and backpressure:
  - Back-to-back ADD/XOR/OR with `out_ready`=1 → one result per cycle.
  - Hold `out_ready`=0 for 3 cycles → result and `out_valid` stable throughout.
  - Release `out_ready` with `in_valid`=1 → retire and accept occur in the same cycle.
- Mid-shift abort:
  - Assert `flush` 2 cycles into SLL shamt=10 → IDLE next cycle, no result emitted, next ADD completes normally.
  - Assert `reset` mid-shift → all outputs 0.
